// File: rtl/ps2_key_decoder_if.sv
// PS/2 receiver bundle: raw keyboard lines in, held key code and pulses out.
// rx_state exposes the frame FSM so checkers can follow frame progress.
interface ps2_key_decoder_if;
   logic        PS2_CLK;
   logic        PS2_DATA;
   logic [15:0] o_ps2_data;
   logic        o_key_strobe;
   logic        o_frame_err;
   logic [1:0]  rx_state;

   // Handshake: none. PS2_CLK/PS2_DATA are free-running async levels.
   // o_key_strobe and o_frame_err are single-cycle pulses with no back-pressure.
   // o_ps2_data is a level that holds until the next make or matching break.
   modport master (
      input  PS2_CLK, PS2_DATA,
      output o_ps2_data, o_key_strobe, o_frame_err, rx_state
   );

   modport slave (
      output PS2_CLK, PS2_DATA,
      input  o_ps2_data, o_key_strobe, o_frame_err, rx_state
   );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: sync + glitch filter, 11-bit frame FSM with timeout,
// and E0/F0 prefix decoder holding the currently pressed key code.
module ps2_key_decoder #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input logic              CLK_50M,
   input logic              RST_N,
   ps2_key_decoder_if.master bus
);

   localparam logic [1:0] RX_IDLE   = 2'd0;
   localparam logic [1:0] RX_DATA   = 2'd1;
   localparam logic [1:0] RX_PARITY = 2'd2;
   localparam logic [1:0] RX_STOP   = 2'd3;

   localparam int FW = $clog2(FILTER_LEN) + 1;
   localparam int TW = $clog2(TIMEOUT_CYC) + 1;

   logic          clk_s1, clk_s2;
   logic          dat_s1, dat_s2;
   logic          filt_clk, filt_prev;
   logic [FW-1:0] filt_cnt;
   logic          fall;

   logic [1:0]    state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par_bit;
   logic [TW-1:0] to_cnt;
   logic          timeout;
   logic          stop_ok;
   logic          err_now;
   logic          byte_valid;
   logic [7:0]    rx_byte;

   logic          ext, brk;
   logic [15:0]   held_code;
   logic [15:0]   code;
   logic          key_strobe;
   logic          frame_err;

   // Two-flop synchronisers, idle-high after reset.
   always_ff @(posedge CLK_50M or negedge RST_N) begin
      if (!RST_N) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= bus.PS2_CLK;
         clk_s2 <= clk_s1;
         dat_s1 <= bus.PS2_DATA;
         dat_s2 <= dat_s1;
      end
   end

   // Filtered clock follows the synced clock only after FILTER_LEN disagreeing samples in a row.
   always_ff @(posedge CLK_50M or negedge RST_N) begin
      if (!RST_N) begin
         filt_clk  <= 1'b1;
         filt_prev <= 1'b1;
         filt_cnt  <= '0;
      end else begin
         filt_prev <= filt_clk;
         if (clk_s2 != filt_clk) begin
            if (filt_cnt == FW'(FILTER_LEN - 1)) begin
               filt_clk <= clk_s2;
               filt_cnt <= '0;
            end else begin
               filt_cnt <= filt_cnt + 1'b1;
            end
         end else begin
            filt_cnt <= '0;
         end
      end
   end

   assign fall    = filt_prev & ~filt_clk;
   assign timeout = (state != RX_IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYC - 1));
   assign stop_ok = dat_s2 && (^{shreg, par_bit});
   assign err_now = timeout || (fall && (state == RX_STOP) && !stop_ok);

   always_ff @(posedge CLK_50M or negedge RST_N) begin
      if (!RST_N) begin
         to_cnt <= '0;
      end else if (fall || state == RX_IDLE || timeout) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   // Frame FSM: start, 8 data bits LSB first, odd parity, stop.
   always_ff @(posedge CLK_50M or negedge RST_N) begin
      if (!RST_N) begin
         state      <= RX_IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         byte_valid <= 1'b0;
         rx_byte    <= '0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= err_now;
         if (timeout) begin
            state <= RX_IDLE;
         end else if (fall) begin
            case (state)
               RX_IDLE: begin
                  if (!dat_s2) begin
                     state   <= RX_DATA;
                     bit_cnt <= '0;
                  end
               end
               RX_DATA: begin
                  shreg   <= {dat_s2, shreg[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= RX_PARITY;
               end
               RX_PARITY: begin
                  par_bit <= dat_s2;
                  state   <= RX_STOP;
               end
               default: begin
                  if (stop_ok) begin
                     byte_valid <= 1'b1;
                     rx_byte    <= shreg;
                  end
                  state <= RX_IDLE;
               end
            endcase
         end
      end
   end

   assign code = {(ext ? 8'hE0 : 8'h00), rx_byte};

   // Prefix decoder: E0/F0 only set flags; any other byte makes or breaks a key.
   always_ff @(posedge CLK_50M or negedge RST_N) begin
      if (!RST_N) begin
         ext        <= 1'b0;
         brk        <= 1'b0;
         held_code  <= '0;
         key_strobe <= 1'b0;
      end else begin
         key_strobe <= 1'b0;
         if (byte_valid) begin
            if (rx_byte == 8'hE0) begin
               ext <= 1'b1;
            end else if (rx_byte == 8'hF0) begin
               brk <= 1'b1;
            end else begin
               if (!brk) begin
                  held_code  <= code;
                  key_strobe <= 1'b1;
               end else if (held_code == code) begin
                  held_code <= '0;
               end
               ext <= 1'b0;
               brk <= 1'b0;
            end
         end
         if (err_now) begin
            ext <= 1'b0;
            brk <= 1'b0;
         end
      end
   end

   assign bus.o_ps2_data   = held_code;
   assign bus.o_key_strobe = key_strobe;
   assign bus.o_frame_err  = frame_err;
   assign bus.rx_state     = state;

endmodule
